// File: rtl/tt_um_rishabhrkaushik_adder_tx_pkg.sv
// rtl/tt_um_rishabhrkaushik_adder_tx_pkg.sv - shared types and constants for the adder UART transmitter
// Contents: FSM state encoding, frame/operand widths, operand adder helper.
`timescale 1ns/1ps
package tt_um_rishabhrkaushik_adder_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_DATA_BITS = 8;
    localparam int SUM_W           = 5;
    localparam int OPND_W          = 4;

    // Zero-extend both operands so the carry lands in the top sum bit.
    function automatic logic [SUM_W-1:0] add_opnds(input logic [OPND_W-1:0] a,
                                                   input logic [OPND_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/tt_um_rishabhrkaushik_adder_tx_sync_rise.sv
// rtl/tt_um_rishabhrkaushik_adder_tx_sync_rise.sv - 2-flop synchronizer with rising-edge detector
// Ports: clk, rst_n (async active-low), async_in (raw pin), rise (1-cycle pulse per accepted rising edge).
`timescale 1ns/1ps
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;
    // settle_q marks the point where sync2 holds a real pin sample rather than
    // its reset value; armed is set once a genuine low level has been seen, so
    // a level held high through reset is never reported as an edge.
    logic [1:0] settle_q;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            settle_q <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sync1    <= async_in;
            sync2    <= sync1;
            prev     <= sync2;
            settle_q <= {settle_q[0], 1'b1};
            armed    <= armed | (settle_q[1] & ~sync2);
        end
    end

    assign rise = sync2 & ~prev & armed;

endmodule

// File: rtl/tt_um_rishabhrkaushik_adder_tx.sv
// rtl/tt_um_rishabhrkaushik_adder_tx.sv - adds two 4-bit operands and sends the sum as a UART 8N1 frame
// Ports: clk, rst_n (async active-low), ena, ui_in[3:0]=A, ui_in[7:4]=B, uio_in[0]=start,
//        uo_out = {done, sum[4:0], busy, tx}, uio_out = 0, uio_oe = 0.
`timescale 1ns/1ps
module tt_um_rishabhrkaushik_adder_tx
    import tt_um_rishabhrkaushik_adder_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(FRAME_DATA_BITS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_DATA_BITS - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_rise;
    logic             bit_end;
    logic [FRAME_DATA_BITS-1:0] payload_d;
    logic             unused_uio;

    sync_rise u_start_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (uio_in[0]),
        .rise     (start_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise && ena) begin
                    state_d = ST_START;
                    baud_d  = '0;
                    idx_d   = '0;
                    sum_d   = add_opnds(ui_in[3:0], ui_in[7:4]);
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    idx_d   = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that the registered tx/busy/done
    // change on the same edge as the state they describe.
    always_comb begin
        payload_d = {{(FRAME_DATA_BITS - SUM_W){1'b0}}, sum_d};
        tx_d      = 1'b1;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_STOP) && (state_d == ST_IDLE);
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = payload_d[idx_d];
            default:  tx_d = 1'b1;
        endcase
    end

    assign uo_out     = {done_q, sum_q, busy_q, tx_q};
    assign uio_out    = 8'h00;
    assign uio_oe     = 8'h00;
    assign unused_uio = &{1'b0, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_rishabhrkaushik_adder_tx.sv
// tb/tb_tt_um_rishabhrkaushik_adder_tx.sv - self-checking bench for the adder UART transmitter
`timescale 1ns/1ps
module tb_tt_um_rishabhrkaushik_adder_tx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests;
    int failed;

    tt_um_rishabhrkaushik_adder_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
        logic [7:0] pay;
        string      name;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // intr_kind: 0 none, 1 second start edge with new operands at intr_cycle,
    // 2 drop ena at intr_cycle.
    task automatic run_frame(input logic [3:0] a, input logic [3:0] b,
                             input logic [4:0] exp_sum, input logic [7:0] exp_pay,
                             input int intr_cycle, input int intr_kind, input string name);
        int bit_err;
        int busy_err;
        int bit_no;
        logic exp_tx;
        bit_err  = 0;
        busy_err = 0;
        @(posedge clk);
        #1;
        ui_in     = {b, a};
        uio_in[0] = 1'b1;
        @(posedge clk);             // E0
        @(negedge clk);
        chk({name, " pre_e0 tx/busy"}, {30'd0, uo_out[1], uo_out[0]}, 32'h1);
        @(posedge clk);             // E1
        @(negedge clk);
        chk({name, " pre_e1 tx/busy"}, {30'd0, uo_out[1], uo_out[0]}, 32'h1);
        @(posedge clk);             // E2
        @(negedge clk);
        chk({name, " e2 tx/busy"}, {30'd0, uo_out[1], uo_out[0]}, 32'h2);
        chk({name, " sum"}, {27'd0, uo_out[6:2]}, {27'd0, exp_sum});
        for (int c = 0; c < 10 * CPB; c++) begin
            bit_no = c / CPB;
            if (bit_no == 0)      exp_tx = 1'b0;
            else if (bit_no <= 8) exp_tx = exp_pay[bit_no-1];
            else                  exp_tx = 1'b1;
            if (uo_out[0] !== exp_tx) bit_err++;
            if (uo_out[1] !== 1'b1 || uo_out[7] !== 1'b0) busy_err++;
            if (c == 2) uio_in[0] = 1'b0;
            if (intr_kind == 1 && c == intr_cycle) begin
                ui_in     = 8'h77;
                uio_in[0] = 1'b1;
            end
            if (intr_kind == 1 && c == intr_cycle + 4) uio_in[0] = 1'b0;
            if (intr_kind == 2 && c == intr_cycle) ena = 1'b0;
            @(negedge clk);
        end
        chk({name, " frame bits"}, bit_err, 0);
        chk({name, " busy held"}, busy_err, 0);
        chk({name, " end done/busy/tx"}, {29'd0, uo_out[7], uo_out[1], uo_out[0]}, 32'h5);
        chk({name, " end sum"}, {27'd0, uo_out[6:2]}, {27'd0, exp_sum});
        @(negedge clk);
        chk({name, " done cleared"}, {31'd0, uo_out[7]}, 32'h0);
    endtask

    task automatic watch_idle(input int cycles, input logic [4:0] exp_sum, input string name);
        int err;
        err = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (uo_out !== {1'b0, exp_sum, 2'b01}) err++;
        end
        chk({name, " stays idle"}, err, 0);
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        ui_in     = 8'h00;
        uio_in    = 8'h00;

        vecs[0] = '{a: 4'd5,  b: 4'd9,  sum: 5'd14, pay: 8'h0E, name: "v5p9"};
        vecs[1] = '{a: 4'd15, b: 4'd15, sum: 5'd30, pay: 8'h1E, name: "v15p15"};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  sum: 5'd0,  pay: 8'h00, name: "v0p0"};
        vecs[3] = '{a: 4'd10, b: 4'd3,  sum: 5'd13, pay: 8'h0D, name: "v10p3"};
        vecs[4] = '{a: 4'd8,  b: 4'd8,  sum: 5'd16, pay: 8'h10, name: "v8p8"};

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset uo_out", {24'd0, uo_out}, 32'h01);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset uo_out", {24'd0, uo_out}, 32'h01);
        chk("uio_oe", {24'd0, uio_oe}, 32'h00);
        chk("uio_out", {24'd0, uio_out}, 32'h00);
        watch_idle(40, 5'd0, "no start");

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].pay, -1, 0, vecs[i].name);
        end

        // Second edge at E2+50 must be dropped; sum stays 14 and only one frame goes out.
        run_frame(4'd5, 4'd9, 5'd14, 8'h0E, 50, 1, "ignore2nd");
        watch_idle(40, 5'd14, "ignore2nd after");
        run_frame(4'd15, 4'd15, 5'd30, 8'h1E, -1, 0, "after done");

        // Start edge with ena low is dropped.
        @(negedge clk);
        ena       = 1'b0;
        ui_in     = 8'h21;
        uio_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        uio_in[0] = 1'b0;
        watch_idle(30, 5'd30, "ena low");
        ena = 1'b1;

        // ena dropped mid-frame does not abort.
        run_frame(4'd6, 4'd7, 5'd13, 8'h0D, 20, 2, "ena drop");
        ena = 1'b1;

        // Reset at E2+70 with start held high through release.
        @(posedge clk);
        #1;
        ui_in     = {4'd9, 4'd5};
        uio_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        repeat (70) @(posedge clk);
        #2;
        chk("pre reset busy", {31'd0, uo_out[1]}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async reset tx/busy", {30'd0, uo_out[1], uo_out[0]}, 32'h1);
        chk("async reset sum", {27'd0, uo_out[6:2]}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        watch_idle(40, 5'd0, "held start");
        uio_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        run_frame(4'd3, 4'd4, 5'd7, 8'h07, -1, 0, "after reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
